// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-serial framed loader that fills instruction memory
// and holds the CPU until a checksum-verified image is in place.
module program_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

  localparam logic [7:0]  HEADER  = 8'hA5;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t            state_q;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       cnt_q;
  logic [ADDR_W:0]   waddr_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [7:0]        csum_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;

  logic              accept;
  logic [15:0]       count_d;
  logic [ADDR_W:0]   waddr_d;

  assign accept  = in_valid && in_ready;
  assign count_d = {cnt_hi_q, in_data};
  // One extra address bit lets N==DEPTH reach its terminal count without wrapping.
  assign waddr_d = waddr_q + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_hi_q     <= '0;
      cnt_q        <= '0;
      waddr_q      <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (accept && in_data == HEADER) state_q <= LEN_HI;
        end
        LEN_HI: begin
          if (accept) begin
            cnt_hi_q <= in_data;
            state_q  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            cnt_q <= count_d;
            if (count_d == 16'd0 || count_d > DEPTH16) begin
              state_q <= ERROR;
            end else begin
              waddr_q    <= '0;
              byte_idx_q <= '0;
              csum_q     <= '0;
              state_q    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_q     <= {word_q[15:0], in_data};
            csum_q     <= csum_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              imem_wdata_q <= {word_q, in_data};
              imem_addr_q  <= waddr_q[ADDR_W-1:0];
              state_q      <= WRITE;
            end
          end
        end
        WRITE: begin
          waddr_q <= waddr_d;
          state_q <= (16'(waddr_d) == cnt_q) ? CSUM : DATA;
        end
        CSUM: begin
          if (accept) state_q <= (in_data == csum_q) ? DONE : ERROR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q != WRITE);
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = (state_q != DONE);
  assign load_done  = (state_q == DONE);
  assign load_error = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized frame stimulus against a frame-level
// reference of expected writes and load outcome.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int          n_total = 0;
  int          n_pass = 0;
  int          rdy_bad = 0;
  int          act_addr[$];
  logic [31:0] act_data[$];
  logic [31:0] frame_words[$];

  program_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // Writes are captured once per cycle; ready must be low exactly when a write is issued.
  always @(negedge clock) begin
    if (reset_n) begin
      if (imem_we) begin
        act_addr.push_back(int'(imem_addr));
        act_data.push_back(imem_wdata);
      end
      if (in_ready === imem_we) rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clock);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("handshake_timeout", guard, 0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input int n, input bit bad, input bit gaps);
    logic [15:0] n16;
    logic [7:0]  cs;
    logic [31:0] w;
    bit          legal;
    int          exp_n;
    n16   = 16'(n);
    legal = (n >= 1) && (n <= 1024);
    exp_n = legal ? n : 0;
    cs    = 8'h00;
    act_addr.delete();
    act_data.delete();
    send_byte(8'hA5, gaps);
    check("hdr_clears_done", load_done, 0);
    check("hdr_clears_error", load_error, 0);
    check("hdr_hold", cpu_hold, 1);
    send_byte(n16[15:8], gaps);
    send_byte(n16[7:0], gaps);
    if (!legal) begin
      check("illegal_error", load_error, 1);
      check("illegal_hold", cpu_hold, 1);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = frame_words[i];
        for (int k = 3; k >= 0; k--) begin
          send_byte(w[k*8 +: 8], gaps);
          cs = cs ^ w[k*8 +: 8];
        end
      end
      send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
      check("end_done", load_done, bad ? 0 : 1);
      check("end_error", load_error, bad ? 1 : 0);
      check("end_hold", cpu_hold, bad ? 1 : 0);
    end
    repeat (2) @(negedge clock);
    check("write_count", act_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < act_addr.size(); i++) begin
      check("wr_addr", act_addr[i], i);
      check("wr_data", act_data[i], frame_words[i]);
    end
  endtask

  task automatic random_words(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back($urandom);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("rst_ready", in_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Junk ahead of the header must be dropped.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check("junk_hold", cpu_hold, 1);
    check("junk_done", load_done, 0);

    frame_words = '{32'h12345678, 32'h9ABCDEF0};
    load_frame(2, 1'b0, 1'b1);
    load_frame(2, 1'b0, 1'b0);
    load_frame(2, 1'b1, 1'b0);
    load_frame(0, 1'b0, 1'b0);
    load_frame(1025, 1'b0, 1'b1);
    frame_words = '{32'h12345678, 32'h9ABCDEF0};
    load_frame(2, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(0, 5))
        0:       n = 0;
        1:       n = 1025 + $urandom_range(0, 64000);
        default: n = $urandom_range(1, 6);
      endcase
      random_words(n);
      load_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    frame_words.delete();
    for (int i = 0; i < 1024; i++) frame_words.push_back(32'(i));
    load_frame(1024, 1'b0, 1'b0);
    check("full_last_addr", (act_addr.size() > 0) ? act_addr[act_addr.size()-1] : -1, 1023);

    // Reset landing while a write is in progress.
    random_words(4);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
    check("pre_rst_we", imem_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ready", in_ready, 1);
    check("async_rst_we", imem_we, 0);
    check("async_rst_hold", cpu_hold, 1);
    check("async_rst_done", load_done, 0);
    check("async_rst_error", load_error, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    load_frame(4, 1'b0, 1'b1);

    check("ready_we_exclusive", rdy_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
